// File: rtl/register_file_pkg.sv
// Shared sizing constants and the byte-lane merge helper for the register file.
`default_nettype none

// +--------------------------------------------------------------------------+
// | register_file_pkg                                                        |
// | Datapath word sizing and byte-enable merge function.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package register_file_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_COUNT  = 16;

  // Merge works on a wide container so callers of any byte-multiple width
  // can size-cast in and out of it.
  localparam int MAX_WIDTH  = 256;
  localparam int MAX_BYTES  = MAX_WIDTH / 8;

  function automatic logic [MAX_WIDTH-1:0] be_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0] be
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_reg_cell.sv
// One storage word with per-byte write enables and an asynchronous clear.
`default_nettype none

// +--------------------------------------------------------------------------+
// | register_file_reg_cell                                                   |
// | WIDTH-bit register, byte-lane writes, async active-low clear.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module register_file_reg_cell
  import register_file_pkg::*;
#(
  parameter int               WIDTH       = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d = WIDTH'(be_merge(MAX_WIDTH'(data_q), MAX_WIDTH'(wr_data), MAX_BYTES'(wr_be)));
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// Multi-register file: one byte-lane write port, two combinational read
// ports, optional hardwired-zero R0 and optional write-to-read bypass.
`default_nettype none

// +--------------------------------------------------------------------------+
// | register_file                                                            |
// | DEPTH x WIDTH register array for the CPU operand buses.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module register_file
  import register_file_pkg::*;
#(
  parameter int               WIDTH       = WORD_WIDTH,
  parameter int               DEPTH       = REG_COUNT,
  parameter bit               ZERO_R0     = 1'b1,
  parameter bit               BYPASS      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              AW          = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [AW-1:0]        rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  input  logic [AW-1:0]        rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b
);

  // Address space is padded to a power of two; unbacked slots read as zero
  // and are never writable, which also covers the hardwired R0.
  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] slot_data [SLOTS];
  logic [SLOTS-1:0] slot_writable;
  logic             wr_live;
  logic [WIDTH-1:0] bypass_data;

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      if ((g >= DEPTH) || (ZERO_R0 && (g == 0))) begin : g_const
        assign slot_data[g]     = '0;
        assign slot_writable[g] = 1'b0;
      end else begin : g_cell
        assign slot_writable[g] = 1'b1;
        register_file_reg_cell #(
          .WIDTH       (WIDTH),
          .RESET_VALUE (RESET_VALUE)
        ) u_cell (
          .clock   (clock),
          .clear   (clear),
          .wr_en   (wr_en && (wr_addr == AW'(g))),
          .wr_be   (wr_be),
          .wr_data (wr_data),
          .rd_data (slot_data[g])
        );
      end
    end
  endgenerate

  assign wr_live     = wr_en && clear && slot_writable[wr_addr];
  assign bypass_data = WIDTH'(be_merge(MAX_WIDTH'(slot_data[wr_addr]), MAX_WIDTH'(wr_data),
                                       MAX_BYTES'(wr_be)));

  always_comb begin
    rd_data_a = slot_data[rd_addr_a];
    if (BYPASS && wr_live && (rd_addr_a == wr_addr)) begin
      rd_data_a = bypass_data;
    end
  end

  always_comb begin
    rd_data_b = slot_data[rd_addr_b];
    if (BYPASS && wr_live && (rd_addr_b == wr_addr)) begin
      rd_data_b = bypass_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Scoreboard bench: four register_file variants share randomized stimulus and
// are checked against an array-based reference model.
`default_nettype none

module tb_register_file;

  localparam int NV = 4;

  logic        clock;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        probe_tg;

  logic [31:0] rda0, rdb0, rda1, rdb1, rda3, rdb3;
  logic [15:0] rda2, rdb2;

  // Variant 0: 32x16, zero R0, bypass.  Variant 1: 32x16, normal R0, no bypass.
  // Variant 2: 16x8, zero R0, bypass.   Variant 3: 32x12, zero R0, bypass, nonzero reset.
  register_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1'b1), .BYPASS(1'b1), .RESET_VALUE(32'h0)) u_main (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb0));

  register_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1'b0), .BYPASS(1'b0), .RESET_VALUE(32'h0)) u_plain (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb1));

  register_file #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1), .RESET_VALUE(16'h0)) u_small (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_be(wr_be[1:0]),
    .wr_data(wr_data[15:0]), .rd_addr_a(rd_addr_a[2:0]), .rd_data_a(rda2),
    .rd_addr_b(rd_addr_b[2:0]), .rd_data_b(rdb2));

  register_file #(.WIDTH(32), .DEPTH(12), .ZERO_R0(1'b1), .BYPASS(1'b1), .RESET_VALUE(32'hCAFEF00D)) u_odd (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda3), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb3));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int          k;
    int          port;
    logic [31:0] expv;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [NV][16];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int vw(int k);  return (k == 2) ? 16 : 32; endfunction
  function automatic int vd(int k);  return (k == 2) ? 8 : ((k == 3) ? 12 : 16); endfunction
  function automatic bit vzr(int k); return k != 1; endfunction
  function automatic bit vbp(int k); return k != 1; endfunction
  function automatic int am(int k);  return (k == 2) ? 7 : 15; endfunction
  function automatic logic [31:0] wmask(int k); return (vw(k) == 16) ? 32'h0000FFFF : 32'hFFFFFFFF; endfunction
  function automatic logic [31:0] vrv(int k); return (k == 3) ? 32'hCAFEF00D : 32'h0; endfunction

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be, int k);
    logic [31:0] v;
    v = old_w;
    for (int i = 0; i < vw(k) / 8; i++) begin
      if (be[i]) v[8*i +: 8] = new_w[8*i +: 8];
    end
    return v & wmask(k);
  endfunction

  function automatic logic [31:0] exp_read(int k, logic [3:0] ra);
    int a;
    logic [31:0] v;
    a = int'(ra) & am(k);
    if (a >= vd(k)) return 32'h0;
    if (vzr(k) && a == 0) return 32'h0;
    v = mdl[k][a];
    if (vbp(k) && clear && wr_en && ((int'(wr_addr) & am(k)) == a)) v = merge(v, wr_data, wr_be, k);
    return v;
  endfunction

  function automatic logic [31:0] get_act(int k, int p);
    case (k)
      0:       return (p == 0) ? rda0 : rdb0;
      1:       return (p == 0) ? rda1 : rdb1;
      2:       return (p == 0) ? {16'h0, rda2} : {16'h0, rdb2};
      default: return (p == 0) ? rda3 : rdb3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      for (int a = 0; a < 16; a++) begin
        mdl[k][a] = (vzr(k) && a == 0) ? 32'h0 : (vrv(k) & wmask(k));
      end
    end
  endtask

  // Applies the write that the DUTs commit on the current rising edge.
  task automatic model_update();
    int a;
    if (clear && wr_en) begin
      for (int k = 0; k < NV; k++) begin
        a = int'(wr_addr) & am(k);
        if (a < vd(k) && !(vzr(k) && a == 0)) mdl[k][a] = merge(mdl[k][a], wr_data, wr_be, k);
      end
    end
  endtask

  task automatic push_all(input string nm);
    exp_t e;
    for (int k = 0; k < NV; k++) begin
      e.k = k; e.nm = nm;
      e.port = 0; e.expv = exp_read(k, rd_addr_a); sb.push_back(e);
      e.port = 1; e.expv = exp_read(k, rd_addr_b); sb.push_back(e);
    end
  endtask

  task automatic step(input string nm, input logic we, input logic [3:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    @(posedge clock);
    model_update();
    #1;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    push_all(nm);
  endtask

  // Drops clear partway through a cycle and checks the outputs before any edge.
  task automatic reset_probe(input string nm);
    @(posedge clock);
    model_update();
    #3;
    clear = 1'b0;
    #1;
    model_reset();
    push_all(nm);
    probe_tg = ~probe_tg;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    clear = 1'b1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clock or probe_tg);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = get_act(e.k, e.port);
        n_cmp++;
        if (act !== e.expv) begin
          n_bad++;
          $display("FAIL %s: dut%0d port %s got %h expected %h", e.nm, e.k,
                   (e.port == 0) ? "a" : "b", act, e.expv);
        end
      end
    end
  end

  initial begin : stimulus
    clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; probe_tg = 1'b0;
    model_reset();

    step("rst_state", 1'b1, 4'd3, 4'hF, 32'hFFFFFFFF, 4'd3, 4'd9);
    release_reset();

    step("wr_r5",   1'b1, 4'd5, 4'hF, 32'h00000005, 4'd0, 4'd1);
    step("rd_r5",   1'b0, 4'd0, 4'h0, 32'h0,        4'd5, 4'd5);

    step("r7_full", 1'b1, 4'd7, 4'hF, 32'h11223344, 4'd7, 4'd6);
    step("r7_lane", 1'b1, 4'd7, 4'h5, 32'hAABBCCDD, 4'd7, 4'd7);
    step("r7_read", 1'b0, 4'd0, 4'h0, 32'h0,        4'd7, 4'd7);

    step("r0_wr",   1'b1, 4'd0, 4'hF, 32'hFFFFFFFF, 4'd0, 4'd0);
    step("r0_read", 1'b0, 4'd0, 4'h0, 32'h0,        4'd0, 4'd0);

    step("r2_init", 1'b1, 4'd2, 4'hF, 32'h00000007, 4'd1, 4'd3);
    step("bypass",  1'b1, 4'd2, 4'hF, 32'h00000101, 4'd2, 4'd2);
    step("post_byp",1'b0, 4'd0, 4'h0, 32'h0,        4'd2, 4'd7);
    step("be_zero", 1'b1, 4'd5, 4'h0, 32'hFFFFFFFF, 4'd5, 4'd5);

    for (int i = 0; i < 4; i++) begin
      step("hold", 1'b0, 4'(i * 3), 4'hF, (i % 2 == 1) ? 32'hFFFFFFFF : 32'h0,
           4'(i + 5), 4'(i + 1));
    end
    for (int a = 0; a < 16; a++) begin
      step("sweep", 1'b0, 4'd0, 4'h0, 32'h0, 4'(a), 4'(15 - a));
    end

    step("r3_wr",     1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 4'd3, 4'd3);
    step("r3_rd",     1'b0, 4'd0, 4'h0, 32'h0,        4'd3, 4'd3);
    reset_probe("async_rst");
    step("rst_ignore",1'b1, 4'd4, 4'hF, 32'h12345678, 4'd4, 4'd3);
    release_reset();
    step("after_rst", 1'b0, 4'd0, 4'h0, 32'h0,        4'd4, 4'd3);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa;
      logic [3:0] ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      step("random", ($urandom_range(0, 3) != 0), wa, 4'($urandom), $urandom, ra,
           ($urandom_range(0, 4) == 0) ? ra : 4'($urandom_range(0, 15)));
      if (i % 100 == 99) begin
        reset_probe("rand_rst");
        release_reset();
      end
    end

    step("drain", 1'b0, 4'd0, 4'h0, 32'h0, 4'd1, 4'd2);
    @(negedge clock);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
